fetch_unit: RTL and testbench

Instruction fetch stage for the 8-bit core. Holds the program counter, drives the program-memory request/acknowledge handshake, and presents one 8-bit instruction per cycle on `inst_reg` to the combinational decoder downstream. It supports execute-stage stalls, taken branches with a pipeline flush, and a squash-next-instruction request for skip-type instructions.

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage for the 8-bit core.
//
// Holds the fetch PC, runs the program-memory req/ack handshake and presents
// one instruction per cycle on inst_reg to the downstream decoder. Handles
// execute stalls (one-word holding buffer), taken branches (flush) and
// skip-type squashes.
//
// Optional feature macro: FETCH_SKIP_EN
//   defined   -> skip squashes the next instruction loaded into inst_reg
//   undefined -> skip is ignored, every fetched word is presented valid
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   imem_req/imem_addr    fetch request and address (addr = fetch_pc)
//   imem_ack/imem_data    memory completion and instruction word, same cycle
//   stall                 decode/execute cannot consume inst_reg
//   branch_en/target      taken branch, redirects fetch and flushes
//   skip                  squash the next instruction
//   inst_reg/inst_valid/pc  instruction register presented to decode
module fetch_unit #(
  parameter int unsigned         PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [7:0]          imem_data,
  input  logic                stall,
  input  logic                branch_en,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                skip,
  output logic [7:0]          inst_reg,
  output logic                inst_valid,
  output logic [PC_WIDTH-1:0] pc
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [7:0]          buf_data;
  logic [PC_WIDTH-1:0] buf_pc;

  logic                accept, mem_hit, load_mem, load_buf, load, squash;
  logic [7:0]          ld_data;
  logic [PC_WIDTH-1:0] ld_pc;

  assign imem_req  = (state == FETCH);
  assign imem_addr = fetch_pc;

  // inst_reg can take a new word when it is empty or being consumed.
  assign accept   = !inst_valid || !stall;
  assign mem_hit  = (state == FETCH) && imem_ack;
  assign load_mem = mem_hit && accept;
  assign load_buf = (state == HOLD) && accept;
  assign load     = load_mem || load_buf;
  assign ld_data  = load_buf ? buf_data : imem_data;
  assign ld_pc    = load_buf ? buf_pc   : fetch_pc;

`ifdef FETCH_SKIP_EN
  logic skip_pending;
  // A skip raised in the same cycle as a load squashes that load directly,
  // so the instruction right after the skip-type one is the one dropped.
  assign squash = skip_pending || skip;

  always_ff @(posedge clk) begin
    if (rst || branch_en)   skip_pending <= 1'b0;
    else if (load)          skip_pending <= 1'b0;
    else if (skip)          skip_pending <= 1'b1;
  end
`else
  logic unused_skip;
  assign unused_skip = skip;
  assign squash      = 1'b0;
`endif

  // Next-state logic; branch overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   if (imem_ack && !accept) state_nxt = HOLD;
      HOLD:    if (accept) state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
    if (branch_en) state_nxt = FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_VECTOR;
      inst_reg   <= 8'h00;
      inst_valid <= 1'b0;
      pc         <= RESET_VECTOR;
    end else if (branch_en) begin
      // Any ack this cycle is dropped; the buffer is abandoned by leaving HOLD.
      fetch_pc   <= branch_target;
      inst_valid <= 1'b0;
    end else begin
      if (mem_hit) begin
        fetch_pc <= fetch_pc + PC_WIDTH'(1);
        if (!accept) begin
          buf_data <= imem_data;
          buf_pc   <= fetch_pc;
        end
      end
      if (load) begin
        inst_reg   <= squash ? 8'h00 : ld_data;
        pc         <= ld_pc;
        inst_valid <= !squash;
      end else if (inst_valid && !stall) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-cycle inputs and expected
// outputs, plus a hand sequence for reset while a request is outstanding.
// Memory model: zero-wait, mem[a] = a+1, ack driven by the table.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst, imem_req, imem_ack, stall, branch_en, skip, inst_valid;
  logic [7:0] imem_addr, imem_data, branch_target, inst_reg, pc;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_SKIP_EN
  localparam bit SKIP_ON = 1'b1;
`else
  localparam bit SKIP_ON = 1'b0;
`endif

  fetch_unit #(.PC_WIDTH(8), .RESET_VECTOR(8'h10)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .stall(stall), .branch_en(branch_en), .branch_target(branch_target),
    .skip(skip),
    .inst_reg(inst_reg), .inst_valid(inst_valid), .pc(pc)
  );

  always #5 clk = ~clk;

  assign imem_data = imem_addr + 8'd1;

  typedef struct {
    logic       st, br, sk, ak;
    logic [7:0] tg;
    logic [7:0] e_inst;
    logic       e_v;
    logic [7:0] e_pc;
    logic       e_req;
    logic [7:0] e_addr;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(input logic st, br, input logic [7:0] tg,
                              input logic sk, ak,
                              input logic [7:0] ei, input logic ev,
                              input logic [7:0] ep, input logic er,
                              input logic [7:0] ea);
    vec_t v;
    v.st = st; v.br = br; v.tg = tg; v.sk = sk; v.ak = ak;
    v.e_inst = ei; v.e_v = ev; v.e_pc = ep; v.e_req = er; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ei,
                         input logic ev, input logic [7:0] ep,
                         input logic er, input logic [7:0] ea);
    chk({tag, ".inst_reg"},   inst_reg, ei);
    chk({tag, ".inst_valid"}, {7'd0, inst_valid}, {7'd0, ev});
    chk({tag, ".pc"},         pc, ep);
    chk({tag, ".imem_req"},   {7'd0, imem_req}, {7'd0, er});
    chk({tag, ".imem_addr"},  imem_addr, ea);
  endtask

  initial begin
    //            st br tg     sk ak  inst   v  pc     req addr
    vec.push_back(mk(0,0,8'h00,0,0, 8'h00,0,8'h10,1,8'h10)); // 0 boot
    vec.push_back(mk(0,0,8'h00,0,1, 8'h11,1,8'h10,1,8'h11)); // 1 first word
    vec.push_back(mk(0,0,8'h00,0,1, 8'h12,1,8'h11,1,8'h12)); // 2
    vec.push_back(mk(0,1,8'h03,0,1, 8'h12,0,8'h11,1,8'h03)); // 3 branch, ack dropped
    vec.push_back(mk(0,0,8'h00,0,1, 8'h04,1,8'h03,1,8'h04)); // 4
    vec.push_back(mk(0,0,8'h00,0,1, 8'h05,1,8'h04,1,8'h05)); // 5
    vec.push_back(mk(0,0,8'h00,0,1, 8'h06,1,8'h05,1,8'h06)); // 6 holds addr 5
    vec.push_back(mk(1,0,8'h00,0,1, 8'h06,1,8'h05,0,8'h07)); // 7 stall, buffer addr 6
    vec.push_back(mk(1,0,8'h00,0,1, 8'h06,1,8'h05,0,8'h07)); // 8 HOLD
    vec.push_back(mk(1,0,8'h00,0,1, 8'h06,1,8'h05,0,8'h07)); // 9 HOLD
    vec.push_back(mk(0,0,8'h00,0,1, 8'h07,1,8'h06,1,8'h07)); // 10 release
    vec.push_back(mk(0,0,8'h00,0,1, 8'h08,1,8'h07,1,8'h08)); // 11 executing 7
    vec.push_back(mk(0,0,8'h00,1,1, SKIP_ON ? 8'h00 : 8'h09, !SKIP_ON,
                     8'h08,1,8'h09));                           // 12 skip
    vec.push_back(mk(0,0,8'h00,0,1, 8'h0A,1,8'h09,1,8'h0A)); // 13
    vec.push_back(mk(1,0,8'h00,0,1, 8'h0A,1,8'h09,0,8'h0B)); // 14 to HOLD
    vec.push_back(mk(1,1,8'h40,0,1, 8'h0A,0,8'h09,1,8'h40)); // 15 branch in HOLD
    vec.push_back(mk(0,0,8'h00,0,1, 8'h41,1,8'h40,1,8'h41)); // 16 target
    vec.push_back(mk(0,0,8'h00,0,0, 8'h41,0,8'h40,1,8'h41)); // 17 wait state
    vec.push_back(mk(0,0,8'h00,0,1, 8'h42,1,8'h41,1,8'h42)); // 18
    vec.push_back(mk(0,1,8'hFE,0,1, 8'h42,0,8'h41,1,8'hFE)); // 19 branch FE
    vec.push_back(mk(0,0,8'h00,0,1, 8'hFF,1,8'hFE,1,8'hFF)); // 20
    vec.push_back(mk(0,0,8'h00,0,0, 8'hFF,0,8'hFE,1,8'hFF)); // 21 bubble
    vec.push_back(mk(0,0,8'h00,0,1, 8'h00,1,8'hFF,1,8'h00)); // 22 wrap
    vec.push_back(mk(0,0,8'h00,0,0, 8'h00,0,8'hFF,1,8'h00)); // 23 bubble
    vec.push_back(mk(0,0,8'h00,0,1, 8'h01,1,8'h00,1,8'h01)); // 24
    vec.push_back(mk(0,0,8'h00,0,0, 8'h01,0,8'h00,1,8'h01)); // 25
    vec.push_back(mk(0,1,8'h20,1,1, 8'h01,0,8'h00,1,8'h20)); // 26 skip+branch
    vec.push_back(mk(0,0,8'h00,0,1, 8'h21,1,8'h20,1,8'h21)); // 27 skip dropped
    vec.push_back(mk(0,0,8'h00,1,0, 8'h21,0,8'h20,1,8'h21)); // 28 skip pends
    vec.push_back(mk(0,0,8'h00,1,1, SKIP_ON ? 8'h00 : 8'h22, !SKIP_ON,
                     8'h21,1,8'h22));                           // 29 squashed
    vec.push_back(mk(0,0,8'h00,0,1, 8'h23,1,8'h22,1,8'h23)); // 30 not cumulative
    vec.push_back(mk(0,0,8'h00,0,0, 8'h23,0,8'h22,1,8'h23)); // 31 pending request

    rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = 8'h00;
    skip = 1'b0; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 8'h00, 1'b0, 8'h10, 1'b0, 8'h10);
    rst = 1'b0;

    for (int i = 0; i < vec.size(); i++) begin
      stall = vec[i].st; branch_en = vec[i].br; branch_target = vec[i].tg;
      skip = vec[i].sk; imem_ack = vec[i].ak;
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), vec[i].e_inst, vec[i].e_v,
              vec[i].e_pc, vec[i].e_req, vec[i].e_addr);
    end

    // Reset while a request is outstanding: abandoned, then refetch.
    stall = 1'b0; branch_en = 1'b0; skip = 1'b0; imem_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all("midrst", 8'h00, 1'b0, 8'h10, 1'b0, 8'h10);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all("reboot", 8'h00, 1'b0, 8'h10, 1'b1, 8'h10);
    imem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all("refetch", 8'h11, 1'b1, 8'h10, 1'b1, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
